fft_pass_scheduler: RTL and testbench



---
 rtl/fft_pass_scheduler.sv | 156 +++++++++++++++
 tb/tb_fft_pass_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_pass_scheduler.sv
// rtl/fft_pass_scheduler.sv - forward/inverse pass sequencer sharing one fft_1024 core
module fft_pass_scheduler #(
  parameter int FFT_LEN = 1024,
  parameter int ADDR_W  = 10,
  parameter int AC_LEN  = 512,
  parameter int PWR_LAT = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              frame_ready,
  input  logic              clear,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  output logic              fft_sink_valid,
  input  logic              fft_sink_ready,
  output logic              fft_sink_sop,
  output logic              fft_sink_eop,
  output logic              fft_inverse,
  input  logic              fft_source_valid,
  input  logic              fft_source_sop,
  input  logic              fft_source_eop,
  output logic              pwr_wr_en,
  output logic              ac_wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       frame_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int PL_W = (PWR_LAT > 1) ? $clog2(PWR_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(FFT_LEN - 1);
  localparam logic [WD_W-1:0]   WD_LIM = WD_W'(TIMEOUT - 1);
  localparam logic [PL_W-1:0]   PL_LIM = PL_W'(PWR_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_FRAME, FWD_FEED, FWD_DRAIN, PWR_WAIT, INV_FEED, INV_DRAIN, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [PL_W-1:0]   pl_q, pl_d;

  logic feeding, draining, sink_beat, src_beat, src_bad;

  assign feeding   = (state_q == FWD_FEED) || (state_q == INV_FEED);
  assign draining  = (state_q == FWD_DRAIN) || (state_q == INV_DRAIN);
  assign sink_beat = feeding && fft_sink_ready;
  assign src_beat  = draining && fft_source_valid;
  // Framing must line up exactly with the beat index; any disagreement is fatal for the frame
  assign src_bad   = src_beat && ((fft_source_sop != (wr_addr_q == '0)) ||
                                  (fft_source_eop != (wr_addr_q == LAST)));

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    frame_count_d = frame_count_q;
    pl_d          = '0;
    case (state_q)
      IDLE:       if (start) state_d = WAIT_FRAME;
      WAIT_FRAME: if (frame_ready) begin
        state_d   = FWD_FEED;
        rd_addr_d = '0;
      end
      FWD_FEED, INV_FEED: begin
        if (sink_beat) begin
          if (rd_addr_q == LAST) begin
            rd_addr_d = '0;
            state_d   = (state_q == FWD_FEED) ? FWD_DRAIN : INV_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end else if (wd_q == WD_LIM) begin
          state_d = ERR;
        end
      end
      FWD_DRAIN, INV_DRAIN: begin
        if (src_bad) begin
          state_d = ERR;
        end else if (src_beat) begin
          if (wr_addr_q == LAST) begin
            wr_addr_d = '0;
            state_d   = (state_q == FWD_DRAIN) ? PWR_WAIT : DONE;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end else if (wd_q == WD_LIM) begin
          state_d = ERR;
        end
      end
      PWR_WAIT: begin
        if (pl_q == PL_LIM) begin
          state_d   = INV_FEED;
          rd_addr_d = '0;
        end else begin
          pl_d = pl_q + 1'b1;
        end
      end
      DONE: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = IDLE;
      end
      ERR:        if (clear) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if ((state_d == ERR) || (state_d == IDLE)) begin
      rd_addr_d = '0;
      wr_addr_d = '0;
    end
    // Watchdog only runs while waiting on the core, and restarts on any progress
    if ((feeding || draining) && (state_d == state_q) && !sink_beat && !src_beat)
      wd_d = wd_q + 1'b1;
    else
      wd_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      frame_count_q <= '0;
      wd_q          <= '0;
      pl_q          <= '0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      frame_count_q <= frame_count_d;
      wd_q          <= wd_d;
      pl_q          <= pl_d;
    end
  end

  assign rd_addr        = rd_addr_q;
  assign wr_addr        = wr_addr_q;
  assign frame_count    = frame_count_q;
  assign rd_sel         = (state_q == INV_FEED) || (state_q == INV_DRAIN);
  assign fft_inverse    = rd_sel;
  assign fft_sink_valid = feeding;
  assign fft_sink_sop   = feeding && (rd_addr_q == '0);
  assign fft_sink_eop   = feeding && (rd_addr_q == LAST);
  assign pwr_wr_en      = (state_q == FWD_DRAIN) && fft_source_valid;
  assign ac_wr_en       = (state_q == INV_DRAIN) && fft_source_valid && (int'(wr_addr_q) < AC_LEN);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign error          = (state_q == ERR);

endmodule

// File: tb/tb_fft_pass_scheduler.sv
// tb/tb_fft_pass_scheduler.sv - directed self-checking bench for fft_pass_scheduler
module tb_fft_pass_scheduler;

  localparam int FFT_LEN = 16;
  localparam int ADDR_W  = 4;
  localparam int AC_LEN  = 8;
  localparam int PWR_LAT = 4;
  localparam int TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, frame_ready, clear;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              rd_sel, fft_sink_valid, fft_sink_ready, fft_sink_sop, fft_sink_eop;
  logic              fft_inverse, fft_source_valid, fft_source_sop, fft_source_eop;
  logic              pwr_wr_en, ac_wr_en, busy, done, error;
  logic [15:0]       frame_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_pass_scheduler #(
    .FFT_LEN(FFT_LEN), .ADDR_W(ADDR_W), .AC_LEN(AC_LEN), .PWR_LAT(PWR_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_ready(frame_ready), .clear(clear),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .fft_sink_valid(fft_sink_valid),
    .fft_sink_ready(fft_sink_ready), .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_inverse(fft_inverse), .fft_source_valid(fft_source_valid),
    .fft_source_sop(fft_source_sop), .fft_source_eop(fft_source_eop),
    .pwr_wr_en(pwr_wr_en), .ac_wr_en(ac_wr_en), .wr_addr(wr_addr), .busy(busy), .done(done),
    .error(error), .frame_count(frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    start = 1'b0; frame_ready = 1'b0; clear = 1'b0;
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0;
  endtask

  task automatic begin_frame();
    next_cycle(); start = 1'b1; #1;
    chk("idle_at_start", {31'd0, busy}, 32'd0);
    next_cycle(); frame_ready = 1'b1; #1;
    chk("wait_frame", {30'd0, busy, fft_sink_valid}, 32'd2);
  endtask

  task automatic feed_pass(input bit inv, input bit bp);
    int a = 0;
    int cyc = 0;
    while (a < FFT_LEN && cyc < 200) begin
      next_cycle();
      fft_sink_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      chk($sformatf("feed%0d_c%0d", inv, cyc),
          {fft_sink_valid, fft_sink_sop, fft_sink_eop, rd_sel, fft_inverse, 27'(rd_addr)},
          {1'b1, a == 0, a == FFT_LEN - 1, inv, inv, 27'(a)});
      if (fft_sink_ready) a++;
      cyc++;
    end
    chk("feed_beats", a, FFT_LEN);
  endtask

  task automatic drain_pass(input bit inv, input bit gaps, input bit drop_eop,
                            input int start_at, input int nbeats);
    int b = 0;
    int cyc = 0;
    logic v;
    while (b < nbeats && cyc < 200) begin
      next_cycle();
      v = gaps ? cyc[0] : 1'b1;
      fft_source_valid = v;
      fft_source_sop   = v && (b == 0);
      fft_source_eop   = v && (b == FFT_LEN - 1) && !drop_eop;
      if (b == start_at) start = 1'b1;
      #1;
      chk($sformatf("drain%0d_c%0d", inv, cyc),
          {fft_sink_valid, fft_inverse, pwr_wr_en, ac_wr_en, 28'(wr_addr)},
          {1'b0, inv, v && !inv, v && inv && (b < AC_LEN), 28'(b)});
      if (v) b++;
      cyc++;
    end
    chk("drain_beats", b, nbeats);
  endtask

  task automatic pwr_wait_check();
    for (int k = 0; k < PWR_LAT; k++) begin
      next_cycle(); #1;
      chk($sformatf("pwr_wait_%0d", k),
          {27'd0, busy, fft_sink_valid, pwr_wr_en, ac_wr_en, done}, 32'h10);
    end
  endtask

  task automatic run_frame(input bit bp, input bit gaps, input int start_at,
                           input logic [15:0] exp_fc);
    begin_frame();
    feed_pass(1'b0, bp);
    drain_pass(1'b0, gaps, 1'b0, start_at, FFT_LEN);
    pwr_wait_check();
    feed_pass(1'b1, bp);
    drain_pass(1'b1, gaps, 1'b0, -1, FFT_LEN);
    next_cycle(); start = 1'b1; #1;
    chk("done_pulse", {29'd0, done, busy, error}, 32'h6);
    next_cycle(); #1;
    chk("after_done", {30'd0, done, busy}, 32'd0);
    chk("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
    next_cycle(); #1;
    chk("start_not_queued", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0; fft_sink_ready = 1'b0;
    start = 1'b0; frame_ready = 1'b0; clear = 1'b0;
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0;
    repeat (3) next_cycle();
    #1;
    chk("reset_outputs", 32'({busy, done, error, fft_sink_valid, fft_sink_sop, fft_sink_eop,
        fft_inverse, rd_sel, pwr_wr_en, ac_wr_en, rd_addr, wr_addr}), 32'd0);
    chk("reset_frame_count", {16'd0, frame_count}, 32'd0);
    next_cycle(); reset_n = 1'b1;

    // nominal frame
    run_frame(1'b0, 1'b0, -1, 16'd1);

    // backpressure 1,0,0,1 with source gaps; start pulsed during forward drain
    run_frame(1'b1, 1'b1, 2, 16'd2);

    // missing eop on final forward beat
    fft_sink_ready = 1'b1;
    begin_frame();
    feed_pass(1'b0, 1'b0);
    drain_pass(1'b0, 1'b0, 1'b1, -1, FFT_LEN);
    next_cycle(); fft_source_valid = 1'b1; start = 1'b1; #1;
    chk("err_entered", {26'd0, error, busy, done, fft_sink_valid, pwr_wr_en, ac_wr_en}, 32'h30);
    next_cycle(); #1;
    chk("err_held", {30'd0, error, done}, 32'h2);
    next_cycle(); clear = 1'b1; #1;
    chk("err_before_clear", {31'd0, error}, 32'd1);
    next_cycle(); #1;
    chk("err_cleared", 32'({error, busy, done, rd_addr, wr_addr}), 32'd0);
    chk("err_frame_count", {16'd0, frame_count}, 32'd2);

    // watchdog in FWD_FEED with ready stuck low
    fft_sink_ready = 1'b0;
    begin_frame();
    for (int k = 0; k < TIMEOUT; k++) begin
      next_cycle(); #1;
      chk($sformatf("timeout_wait_%0d", k), {26'd0, error, fft_sink_valid, rd_addr}, 32'h10);
    end
    next_cycle(); #1;
    chk("timeout_err", {30'd0, error, fft_sink_valid}, 32'h2);
    next_cycle(); clear = 1'b1;
    next_cycle(); #1;
    chk("timeout_cleared", {30'd0, error, busy}, 32'd0);

    // reset at inverse drain beat 3
    fft_sink_ready = 1'b1;
    begin_frame();
    feed_pass(1'b0, 1'b0);
    drain_pass(1'b0, 1'b0, 1'b0, -1, FFT_LEN);
    pwr_wait_check();
    feed_pass(1'b1, 1'b0);
    drain_pass(1'b1, 1'b0, 1'b0, -1, 3);
    next_cycle(); fft_source_valid = 1'b1; reset_n = 1'b0; #1;
    chk("beat3_before_reset", {27'd0, ac_wr_en, wr_addr}, 32'h13);
    next_cycle(); reset_n = 1'b1; fft_source_valid = 1'b1; #1;
    chk("mid_reset_outputs", 32'({busy, done, error, fft_sink_valid, fft_sink_sop, fft_sink_eop,
        fft_inverse, rd_sel, pwr_wr_en, ac_wr_en, rd_addr, wr_addr}), 32'd0);
    chk("mid_reset_frame_count", {16'd0, frame_count}, 32'd0);
    run_frame(1'b0, 1'b0, -1, 16'd1);

    // frame_count wrap 65535 -> 0
    next_cycle();
    force dut.frame_count_q = 16'hffff;
    @(posedge clk);
    next_cycle();
    release dut.frame_count_q;
    #1;
    chk("preload_count", {16'd0, frame_count}, 32'hffff);
    run_frame(1'b0, 1'b1, -1, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
